// File: rtl/ex_operand_stage.sv
// Purpose  : ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the ALU.
// Latency  : 1 cycle from an accepted ID instruction to valid EX outputs; forwarding is combinational.
// Backpressure: id_ready drops on ex_stall or a load-use hazard; flush kills EX, and a stall holds it.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   id_*                         decoded instruction from ID (valid/ready handshake)
//   ex_stall, flush              downstream hold / taken-branch kill
//   mem_*, wb_*                  producer info from EX/MEM and MEM/WB for bypassing
//   ex_*                         registered instruction and forwarded operands for the ALU
// Optional build macro LOAD_USE_STATS_EN adds stall_count / bubble_count (32-bit, wrapping).
module ex_operand_stage #(
  parameter int ALU_BITS      = 32,
  parameter int ALU_CTRL_BITS = 4,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [REG_ADDR_BITS-1:0] id_rs1,
  input  logic [REG_ADDR_BITS-1:0] id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_ADDR_BITS-1:0] id_rd,
  input  logic [ALU_BITS-1:0]      id_rdata1,
  input  logic [ALU_BITS-1:0]      id_rdata2,
  input  logic [ALU_BITS-1:0]      id_imm,
  input  logic                     id_alu_src,
  input  logic [ALU_CTRL_BITS-1:0] id_alu_ctrl,
  input  logic                     id_mem_read,
  input  logic                     id_reg_write,
  input  logic                     ex_stall,
  input  logic                     flush,
  input  logic                     mem_reg_write,
  input  logic [REG_ADDR_BITS-1:0] mem_rd,
  input  logic [ALU_BITS-1:0]      mem_result,
  input  logic                     wb_reg_write,
  input  logic [REG_ADDR_BITS-1:0] wb_rd,
  input  logic [ALU_BITS-1:0]      wb_result,
  output logic                     ex_valid,
  output logic [ALU_BITS-1:0]      ex_rdata1,
  output logic [ALU_BITS-1:0]      ex_rdata2,
  output logic [ALU_BITS-1:0]      ex_imm,
  output logic                     ex_alu_src,
  output logic [ALU_CTRL_BITS-1:0] ex_alu_ctrl,
  output logic [REG_ADDR_BITS-1:0] ex_rd,
  output logic                     ex_mem_read,
  output logic                     ex_reg_write
`ifdef LOAD_USE_STATS_EN
  ,
  output logic [31:0]              stall_count,
  output logic [31:0]              bubble_count
`endif
);

  logic                     valid_q,     valid_d;
  logic [REG_ADDR_BITS-1:0] rs1_q,       rs1_d;
  logic [REG_ADDR_BITS-1:0] rs2_q,       rs2_d;
  logic                     rs1_used_q,  rs1_used_d;
  logic                     rs2_used_q,  rs2_used_d;
  logic [ALU_BITS-1:0]      rdata1_q,    rdata1_d;
  logic [ALU_BITS-1:0]      rdata2_q,    rdata2_d;
  logic [ALU_BITS-1:0]      imm_q,       imm_d;
  logic                     alu_src_q,   alu_src_d;
  logic [ALU_CTRL_BITS-1:0] alu_ctrl_q,  alu_ctrl_d;
  logic [REG_ADDR_BITS-1:0] rd_q,        rd_d;
  logic                     mem_read_q,  mem_read_d;
  logic                     reg_write_q, reg_write_d;

  logic load_use;
  logic xfer;
  logic kill;
  logic wb_hit1, wb_hit2;

  always_comb begin
    load_use = valid_q & mem_read_q & (rd_q != '0) &
               ((id_rs1_used & (id_rs1 == rd_q)) | (id_rs2_used & (id_rs2 == rd_q)));
    id_ready = ~ex_stall & ~load_use;
    xfer     = id_valid & id_ready & ~flush;
    // Flush beats stall; with no stall and nothing accepted, EX becomes a bubble.
    kill     = flush | (~ex_stall & ~xfer);
    wb_hit1  = wb_reg_write & (wb_rd != '0) & (wb_rd == rs1_q);
    wb_hit2  = wb_reg_write & (wb_rd != '0) & (wb_rd == rs2_q);
  end

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_used_d  = rs1_used_q;
    rs2_used_d  = rs2_used_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    alu_ctrl_d  = alu_ctrl_q;
    rd_d        = rd_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    if (kill) begin
      // Bubble: control zeroed so it is an inert ADD; clearing the used flags
      // keeps a dead slot from matching producers.
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
      alu_ctrl_d  = '0;
      rs1_used_d  = 1'b0;
      rs2_used_d  = 1'b0;
    end else if (ex_stall) begin
      // A held instruction may outlive its MEM/WB producer; capture the value
      // while it is still visible so it survives once the producer retires.
      if (valid_q && rs1_used_q && wb_hit1) rdata1_d = wb_result;
      if (valid_q && rs2_used_q && wb_hit2) rdata2_d = wb_result;
    end else begin
      valid_d     = 1'b1;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rs1_used_d  = id_rs1_used;
      rs2_used_d  = id_rs2_used;
      rdata1_d    = id_rdata1;
      rdata2_d    = id_rdata2;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      alu_ctrl_d  = id_alu_ctrl;
      rd_d        = id_rd;
      mem_read_d  = id_mem_read;
      reg_write_d = id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_used_q  <= 1'b0;
      rs2_used_q  <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      rd_q        <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_used_q  <= rs1_used_d;
      rs2_used_q  <= rs2_used_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rd_q        <= rd_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Operand bypass: EX/MEM is younger than MEM/WB so it wins; x0 never forwards.
  always_comb begin
    ex_rdata1 = rdata1_q;
    if (rs1_used_q && mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q)) ex_rdata1 = mem_result;
    else if (rs1_used_q && wb_hit1)                                         ex_rdata1 = wb_result;
    ex_rdata2 = rdata2_q;
    if (rs2_used_q && mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q)) ex_rdata2 = mem_result;
    else if (rs2_used_q && wb_hit2)                                         ex_rdata2 = wb_result;
  end

  assign ex_valid     = valid_q;
  assign ex_imm       = imm_q;
  assign ex_alu_src   = alu_src_q;
  assign ex_alu_ctrl  = alu_ctrl_q;
  assign ex_rd        = rd_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;

`ifdef LOAD_USE_STATS_EN
  logic [31:0] stall_count_q,  stall_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    stall_count_d  = stall_count_q;
    bubble_count_d = bubble_count_q;
    if (load_use && id_valid && !ex_stall && !flush) stall_count_d = stall_count_q + 32'd1;
    if (kill) bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_count_q  <= stall_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Purpose  : self-checking bench for ex_operand_stage (directed scenarios + randomized model check).
// Latency  : expects registered EX fields one edge after acceptance; operands combinational.
// Backpressure: drives ex_stall/flush and hazards, checks id_ready against the model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_ctrl;
  logic        id_mem_read, id_reg_write;
  logic        ex_stall, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_alu_src, ex_mem_read, ex_reg_write;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
`ifdef LOAD_USE_STATS_EN
  logic [31:0] stall_count, bubble_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .ex_stall(ex_stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_alu_src(ex_alu_src), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
`ifdef LOAD_USE_STATS_EN
    , .stall_count(stall_count), .bubble_count(bubble_count)
`endif
  );

  // Reference view of the instruction sitting in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [31:0] d1, d2, imm;
    logic        src;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        mr, rw;
  } ex_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd = 0;
    id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_alu_src = 0; id_alu_ctrl = 0;
    id_mem_read = 0; id_reg_write = 0; ex_stall = 0; flush = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0; wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic mr, input logic rw);
    id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_alu_src = 1; id_alu_ctrl = 4'h3;
    id_mem_read = mr; id_reg_write = rw;
  endtask

  function automatic logic [31:0] fwd(input logic u, input logic [4:0] rs, input logic [31:0] lat);
    if (u && rs != 0 && mem_reg_write && mem_rd == rs) return mem_result;
    if (u && rs != 0 && wb_reg_write && wb_rd == rs)   return wb_result;
    return lat;
  endfunction

  task automatic test_reset;
    set_idle();
    rst = 1;
    issue(5'd1, 1, 5'd2, 1, 5'd3, 32'hdead, 32'hbeef, 32'h77, 1, 1);
    ex_stall = 1;
    tick();
    ex_stall = 0;
    tick();
    rst = 0;
    set_idle();
    #1;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", ex_valid); else n_pass++;
    n_checks++; if (ex_imm !== 32'h0) $display("FAIL rst_imm got=%0h exp=0", ex_imm); else n_pass++;
    n_checks++; if (ex_alu_src !== 1'b0) $display("FAIL rst_src got=%0h exp=0", ex_alu_src); else n_pass++;
    n_checks++; if (ex_alu_ctrl !== 4'h0) $display("FAIL rst_ctrl got=%0h exp=0", ex_alu_ctrl); else n_pass++;
    n_checks++; if (ex_rd !== 5'h0) $display("FAIL rst_rd got=%0h exp=0", ex_rd); else n_pass++;
    n_checks++; if (ex_mem_read !== 1'b0) $display("FAIL rst_mr got=%0h exp=0", ex_mem_read); else n_pass++;
    n_checks++; if (ex_reg_write !== 1'b0) $display("FAIL rst_rw got=%0h exp=0", ex_reg_write); else n_pass++;
    n_checks++; if (ex_rdata1 !== 32'h0) $display("FAIL rst_rdata1 got=%0h exp=0", ex_rdata1); else n_pass++;
    n_checks++; if (ex_rdata2 !== 32'h0) $display("FAIL rst_rdata2 got=%0h exp=0", ex_rdata2); else n_pass++;
    n_checks++; if (id_ready !== 1'b1) $display("FAIL rst_ready got=%0h exp=1", id_ready); else n_pass++;
  endtask

  task automatic test_forward;
    set_idle();
    issue(5'd0, 0, 5'd0, 0, 5'd5, 0, 0, 0, 0, 1);
    tick();
    issue(5'd5, 1, 5'd5, 0, 5'd6, 32'h33, 32'h44, 0, 0, 1);
    tick();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 5; mem_result = 32'h0000_00AA;
    #1;
    n_checks++; if (ex_rdata1 !== 32'hAA) $display("FAIL fwd_mem got=%0h exp=aa", ex_rdata1); else n_pass++;
    n_checks++; if (ex_rdata2 !== 32'h44) $display("FAIL fwd_unused got=%0h exp=44", ex_rdata2); else n_pass++;
    wb_reg_write = 1; wb_rd = 5; wb_result = 32'h11;
    #1;
    n_checks++; if (ex_rdata1 !== 32'hAA) $display("FAIL fwd_prio got=%0h exp=aa", ex_rdata1); else n_pass++;
    mem_reg_write = 0;
    #1;
    n_checks++; if (ex_rdata1 !== 32'h11) $display("FAIL fwd_wb got=%0h exp=11", ex_rdata1); else n_pass++;
    wb_reg_write = 0;
    #1;
    n_checks++; if (ex_rdata1 !== 32'h33) $display("FAIL fwd_none got=%0h exp=33", ex_rdata1); else n_pass++;
  endtask

  task automatic test_load_use;
    set_idle();
    tick();
    issue(5'd0, 0, 5'd0, 0, 5'd7, 0, 0, 0, 1, 1);
    tick();
    issue(5'd1, 1, 5'd7, 1, 5'd8, 32'h1, 32'h2, 32'h9, 0, 1);
    #1;
    n_checks++; if (id_ready !== 1'b0) $display("FAIL lu_ready got=%0h exp=0", id_ready); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble got=%0h exp=0", ex_valid); else n_pass++;
    n_checks++; if (id_ready !== 1'b1) $display("FAIL lu_ready2 got=%0h exp=1", id_ready); else n_pass++;
    tick();
    id_valid = 0;
    #1;
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8)
      $display("FAIL lu_accept got=%0h/%0d exp=1/8", ex_valid, ex_rd); else n_pass++;
  endtask

  task automatic test_stall_refresh;
    set_idle();
    issue(5'd3, 1, 5'd0, 0, 5'd9, 32'h55, 0, 0, 0, 1);
    tick();
    issue(5'd1, 0, 5'd2, 0, 5'd10, 0, 0, 0, 0, 1);
    ex_stall = 1;
    #1;
    n_checks++; if (id_ready !== 1'b0) $display("FAIL st_ready got=%0h exp=0", id_ready); else n_pass++;
    tick();
    wb_reg_write = 1; wb_rd = 3; wb_result = 32'h1234;
    #1;
    n_checks++; if (ex_rdata1 !== 32'h1234) $display("FAIL st_fwd got=%0h exp=1234", ex_rdata1); else n_pass++;
    tick();
    wb_rd = 4; wb_result = 32'hDEAD;
    tick();
    ex_stall = 0; id_valid = 0;
    #1;
    n_checks++; if (ex_rdata1 !== 32'h1234) $display("FAIL st_keep got=%0h exp=1234", ex_rdata1); else n_pass++;
    n_checks++; if (ex_rd !== 5'd9) $display("FAIL st_hold_rd got=%0d exp=9", ex_rd); else n_pass++;
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL st_valid got=%0h exp=1", ex_valid); else n_pass++;
  endtask

  task automatic test_flush;
    set_idle();
    issue(5'd0, 0, 5'd0, 0, 5'd11, 0, 0, 32'h5, 1, 1);
    tick();
    issue(5'd0, 0, 5'd0, 0, 5'd12, 0, 0, 32'h99, 0, 1);
    ex_stall = 1; flush = 1;
    #1;
    n_checks++; if (id_ready !== 1'b0) $display("FAIL fl_ready got=%0h exp=0", id_ready); else n_pass++;
    tick();
    set_idle();
    #1;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL fl_valid got=%0h exp=0", ex_valid); else n_pass++;
    n_checks++; if (ex_reg_write !== 1'b0) $display("FAIL fl_rw got=%0h exp=0", ex_reg_write); else n_pass++;
    n_checks++; if (ex_mem_read !== 1'b0 || ex_alu_ctrl !== 4'h0)
      $display("FAIL fl_ctrl got=%0h/%0h exp=0/0", ex_mem_read, ex_alu_ctrl); else n_pass++;
    n_checks++; if (ex_rd === 5'd12 || ex_imm === 32'h99)
      $display("FAIL fl_capture got rd=%0d imm=%0h exp not 12/99", ex_rd, ex_imm); else n_pass++;
  endtask

  task automatic test_x0;
    set_idle();
    issue(5'd0, 1, 5'd0, 1, 5'd1, 32'h0, 32'h0, 0, 0, 1);
    tick();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'hFFFF_FFFF;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (ex_rdata1 !== 32'h0 || ex_rdata2 !== 32'h0)
      $display("FAIL x0_fwd got=%0h/%0h exp=0/0", ex_rdata1, ex_rdata2); else n_pass++;
  endtask

  task automatic test_random;
    ex_t m, n;
    logic lu, rdy, acc;
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    m = '0;
    for (int c = 0; c < 800; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
      id_alu_src = 1'($urandom_range(0, 1)); id_alu_ctrl = 4'($urandom_range(0, 15));
      id_mem_read = ($urandom_range(0, 2) == 0); id_reg_write = 1'($urandom_range(0, 1));
      ex_stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      mem_reg_write = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      #1;
      lu  = m.v && m.mr && m.rd != 0 &&
            ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
      rdy = !ex_stall && !lu;
      acc = id_valid && rdy && !flush;
      n_checks++; if (id_ready !== rdy) $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, id_ready, rdy); else n_pass++;
      if (m.v) begin
        n_checks++; if (ex_rdata1 !== fwd(m.u1, m.rs1, m.d1))
          $display("FAIL rnd_op1 c=%0d got=%0h exp=%0h", c, ex_rdata1, fwd(m.u1, m.rs1, m.d1)); else n_pass++;
        n_checks++; if (ex_rdata2 !== fwd(m.u2, m.rs2, m.d2))
          $display("FAIL rnd_op2 c=%0d got=%0h exp=%0h", c, ex_rdata2, fwd(m.u2, m.rs2, m.d2)); else n_pass++;
      end
      n = m;
      if (flush || (!ex_stall && !acc)) begin
        n.v = 0; n.mr = 0; n.rw = 0; n.ctrl = 0;
      end else if (ex_stall) begin
        if (m.v && m.u1 && m.rs1 != 0 && wb_reg_write && wb_rd == m.rs1) n.d1 = wb_result;
        if (m.v && m.u2 && m.rs2 != 0 && wb_reg_write && wb_rd == m.rs2) n.d2 = wb_result;
      end else begin
        n = '{v: 1'b1, rs1: id_rs1, rs2: id_rs2, u1: id_rs1_used, u2: id_rs2_used,
              d1: id_rdata1, d2: id_rdata2, imm: id_imm, src: id_alu_src, ctrl: id_alu_ctrl,
              rd: id_rd, mr: id_mem_read, rw: id_reg_write};
      end
      m = n;
      tick();
      n_checks++; if (ex_valid !== m.v || ex_mem_read !== m.mr || ex_reg_write !== m.rw || ex_alu_ctrl !== m.ctrl)
        $display("FAIL rnd_ctrl c=%0d got=%0h%0h%0h/%0h exp=%0h%0h%0h/%0h", c, ex_valid, ex_mem_read,
                 ex_reg_write, ex_alu_ctrl, m.v, m.mr, m.rw, m.ctrl); else n_pass++;
      if (m.v) begin
        n_checks++; if (ex_rd !== m.rd || ex_imm !== m.imm || ex_alu_src !== m.src)
          $display("FAIL rnd_fields c=%0d got=%0d/%0h/%0h exp=%0d/%0h/%0h", c, ex_rd, ex_imm, ex_alu_src,
                   m.rd, m.imm, m.src); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_stall_refresh();
    test_flush();
    test_x0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
